// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave). At most one request is outstanding.
//
// Signals
//   o_imem_req    master->slave  request valid
//   o_imem_addr   master->slave  request byte address (current PC)
//   i_imem_gnt    slave->master  memory accepts the request this cycle
//   i_imem_rvalid slave->master  read data valid
//   i_imem_rdata  slave->master  instruction word
// ---------------------------------------------------------------------------
interface fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Fetches one instruction at a time from instruction memory, presents it to
// decode with a valid/ready handshake and computes the next PC from the
// control-flow select sampled when decode accepts the instruction.
// A misaligned next PC raises a sticky flag and stops fetching until reset.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst_n        asynchronous active-low reset
//   imem           instruction-memory bus (fetch_unit_if.master)
//   o_instr        captured instruction (NOP_INSTR until the first capture)
//   o_pc           PC of o_instr
//   o_instr_valid  o_instr/o_pc valid
//   i_instr_ready  decode consumes the instruction this cycle
//   i_pc_sel       next-PC select: 00 PC+4, 01 branch, 10 JAL, 11 JALR
//   i_br_target    target for select 01 and 10
//   i_jalr_target  target for select 11 (bit 0 cleared)
//   o_misalign     sticky misaligned-next-PC flag
//   o_fetch_count  number of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        o_instr,
    output logic [31:0]        o_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic [1:0]         i_pc_sel,
    input  logic [31:0]        i_br_target,
    input  logic [31:0]        i_jalr_target,
    output logic               o_misalign,
    output logic [31:0]        o_fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        VALID,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic        req;
    logic [31:0] next_pc;

    // Next PC candidate; only consumed on accept.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc = pc + 32'd4;
        case (i_pc_sel)
            2'b01,
            2'b10:   next_pc = i_br_target;
            2'b11:   next_pc = i_jalr_target & ~32'd1;
            default: next_pc = pc + 32'd4;
        endcase
    end

    // Single state machine; request and valid are registered alongside the
    // state so no handshake input reaches an output combinationally.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            o_instr       <= NOP_INSTR;
            o_pc          <= RESET_PC;
            req           <= 1'b0;
            o_instr_valid <= 1'b0;
            o_misalign    <= 1'b0;
            fetch_count   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end
                FETCH: begin
                    // Address is the PC register itself, so it holds while gnt is low.
                    if (imem.i_imem_gnt) begin
                        state <= WAIT;
                        req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem.i_imem_rvalid) begin
                        o_instr       <= imem.i_imem_rdata;
                        o_pc          <= pc;
                        o_instr_valid <= 1'b1;
                        state         <= VALID;
                    end
                end
                VALID: begin
                    if (i_instr_ready) begin
                        fetch_count   <= fetch_count + 32'd1;
                        o_instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            // PC stays put so it still points at the faulting flow.
                            o_misalign <= 1'b1;
                            state      <= HALT;
                        end else begin
                            pc    <= next_pc;
                            req   <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    req           <= 1'b0;
                    o_instr_valid <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    req           <= 1'b0;
                    o_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.o_imem_req  = req;
    assign imem.o_imem_addr = pc;
    assign o_fetch_count    = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit through directed scenarios and randomized traffic and
// compares every cycle against a transaction-level reference model.
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic [31:0] opc;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  pc_sel;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic        misalign;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .imem          (bus),
        .o_instr       (instr),
        .o_pc          (opc),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .i_pc_sel      (pc_sel),
        .i_br_target   (br_target),
        .i_jalr_target (jalr_target),
        .o_misalign    (misalign),
        .o_fetch_count (fetch_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks where the current instruction transaction stands, the PC it
    // belongs to, and the architectural counters.
    typedef enum {M_IDLE, M_REQ, M_WAIT, M_VALID, M_HALT} phase_t;

    phase_t      m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic [31:0] m_count;
    logic        m_misalign;

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] sel,
                                             input logic [31:0] br, input logic [31:0] jalr);
        case (sel)
            2'd0:    return pc + 32'd4;
            2'd3:    return {jalr[31:1], 1'b0};
            default: return br;
        endcase
    endfunction

    task automatic model_reset();
        m_phase    = M_IDLE;
        m_pc       = RESET_PC;
        m_instr    = NOP_INSTR;
        m_opc      = RESET_PC;
        m_count    = 32'd0;
        m_misalign = 1'b0;
    endtask

    task automatic compare();
        check("imem_req", 32'(bus.o_imem_req), 32'(m_phase == M_REQ));
        if (m_phase == M_REQ) check("imem_addr", bus.o_imem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_phase == M_VALID));
        check("instr", instr, m_instr);
        if (m_phase == M_VALID) check("pc", opc, m_opc);
        check("misalign", 32'(misalign), 32'(m_misalign));
        check("fetch_count", fetch_count, m_count);
    endtask

    // One clock cycle: check outputs, apply inputs, advance the model, clock.
    task automatic step(input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic rdy, input logic [1:0] sel,
                        input logic [31:0] br, input logic [31:0] jalr);
        logic [31:0] nxt;
        compare();
        bus.i_imem_gnt    = gnt;
        bus.i_imem_rvalid = rv;
        bus.i_imem_rdata  = rdata;
        instr_ready       = rdy;
        pc_sel            = sel;
        br_target         = br;
        jalr_target       = jalr;
        case (m_phase)
            M_IDLE: m_phase = M_REQ;
            M_REQ:  if (gnt) m_phase = M_WAIT;
            M_WAIT: if (rv) begin
                m_instr = rdata;
                m_opc   = m_pc;
                m_phase = M_VALID;
            end
            M_VALID: if (rdy) begin
                m_count = m_count + 32'd1;
                nxt     = ref_next(m_pc, sel, br, jalr);
                if (nxt % 4 != 0) begin
                    m_misalign = 1'b1;
                    m_phase    = M_HALT;
                end else begin
                    m_pc    = nxt;
                    m_phase = M_REQ;
                end
            end
            default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    // Complete one instruction with the given handshake delays. Stray rvalid
    // pulses are driven outside WAIT to confirm they are ignored.
    task automatic fetch_one(input logic [31:0] rdata, input int gnt_delay, input int rv_delay,
                             input int rdy_delay, input logic [1:0] sel,
                             input logic [31:0] br, input logic [31:0] jalr);
        for (int i = 0; i < 4 && m_phase != M_REQ; i++) idle();
        repeat (gnt_delay) step(1'b0, 1'b1, 32'hBAD0_0001, 1'b1, 2'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 32'hBAD0_0002, 1'b1, 2'd0, 32'd0, 32'd0);
        repeat (rv_delay - 1) step(1'b0, 1'b0, 32'hBAD0_0003, 1'b1, 2'd0, 32'd0, 32'd0);
        step(1'b0, 1'b1, rdata, 1'b0, 2'd0, 32'd0, 32'd0);
        repeat (rdy_delay) step(1'b0, 1'b1, 32'hBAD0_0004, 1'b0, 2'd1, 32'h0000_0abc, 32'd0);
        step(1'b0, 1'b0, 32'hBAD0_0005, 1'b1, sel, br, jalr);
    endtask

    // Assert reset mid-cycle, check that outputs clear without a clock edge,
    // hold it across one rising edge and release on a falling edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", 32'(bus.o_imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pc", opc, RESET_PC);
        check("rst_addr", bus.o_imem_addr, RESET_PC);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        model_reset();
        bus.i_imem_gnt    = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        instr_ready       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] br;
        logic [31:0] jalr;
        bus.i_imem_gnt    = 1'b0;
        bus.i_imem_rvalid = 1'b0;
        bus.i_imem_rdata  = 32'd0;
        instr_ready       = 1'b0;
        pc_sel            = 2'd0;
        br_target         = 32'd0;
        jalr_target       = 32'd0;
        model_reset();
        @(negedge clk);

        // Minimum-latency fetch from reset, sequential next PC.
        do_reset();
        fetch_one(32'h0050_0093, 0, 1, 0, 2'd0, 32'd0, 32'd0);
        check("seq_addr", bus.o_imem_addr, 32'h4);

        // Walk to PC 0x10, then take a branch to 0x40.
        fetch_one(32'h0000_0013, 0, 1, 0, 2'd0, 32'd0, 32'd0);
        fetch_one(32'h0000_0013, 0, 1, 0, 2'd0, 32'd0, 32'd0);
        fetch_one(32'h0000_0013, 0, 1, 0, 2'd0, 32'd0, 32'd0);
        check("br_from_pc", bus.o_imem_addr, 32'h10);
        fetch_one(32'h0000_0063, 0, 1, 0, 2'd1, 32'h40, 32'd0);
        check("br_addr", bus.o_imem_addr, 32'h40);
        check("br_count", fetch_count, 32'd5);

        // JAL uses the branch target too.
        fetch_one(32'h0000_006f, 0, 1, 0, 2'd2, 32'h80, 32'd0);
        check("jal_addr", bus.o_imem_addr, 32'h80);

        // JALR clears bit 0; a target with bit 1 set halts fetching.
        fetch_one(32'h0000_0067, 0, 1, 0, 2'd3, 32'd0, 32'h0000_0101);
        check("jalr_addr", bus.o_imem_addr, 32'h100);
        fetch_one(32'h0000_0067, 0, 1, 0, 2'd3, 32'd0, 32'h0000_0102);
        repeat (5) step(1'b1, 1'b1, 32'h1234_5678, 1'b1, 2'd0, 32'd0, 32'd0);
        check("halt_misalign", 32'(misalign), 32'd1);
        check("halt_no_req", 32'(bus.o_imem_req), 32'd0);
        check("halt_count", fetch_count, 32'd8);

        // Stretched handshake: gnt late, rvalid late, ready late.
        do_reset();
        fetch_one(32'hCAFE_F00D, 3, 2, 4, 2'd0, 32'd0, 32'd0);
        check("slow_addr", bus.o_imem_addr, 32'h4);

        // Reset while a response is pending; the late rvalid must be ignored.
        idle();
        step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 32'd0);
        do_reset();
        step(1'b0, 1'b1, 32'hFEED_0001, 1'b0, 2'd0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'hFEED_0002, 1'b0, 2'd0, 32'd0, 32'd0);
        check("late_rv_req", 32'(bus.o_imem_req), 32'd1);
        check("late_rv_addr", bus.o_imem_addr, RESET_PC);
        check("late_rv_count", fetch_count, 32'd0);
        check("late_rv_instr", instr, NOP_INSTR);

        // Counter wrap and sequential PC wrap at the top of the address space.
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        m_count = 32'hFFFF_FFFF;
        fetch_one(32'h0000_0063, 0, 1, 0, 2'd1, 32'hFFFF_FFFC, 32'd0);
        check("wrap_count", fetch_count, 32'd0);
        check("wrap_top_addr", bus.o_imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h0000_0013, 0, 1, 0, 2'd0, 32'd0, 32'd0);
        check("wrap_pc_addr", bus.o_imem_addr, 32'h0);

        // Randomized traffic, including stray rvalid and occasional misalignment.
        for (int ep = 0; ep < 15; ep++) begin
            do_reset();
            for (int cyc = 0; cyc < 150; cyc++) begin
                br = $urandom & ~32'd3;
                if ($urandom_range(0, 9) == 0) br = br | 32'($urandom_range(1, 3));
                jalr = $urandom & ~32'd2;
                if ($urandom_range(0, 9) == 0) jalr = jalr | 32'd2;
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), $urandom,
                     1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), br, jalr);
            end
        end
        compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
